// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal/vertical counters with registered sync,
// active-area, address and end-of-frame outputs.
module vga_sync_gen #(
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 23,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FRONT  = 1,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        sync_en,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Ready_Sig,
  output logic [11:0] Column_Addr_Sig,
  output logic [11:0] Row_Addr_Sig,
  output logic        Frame_Sig
);

  // Counter/address width; both totals are expected to fit in 4096.
  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_ACT_S = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_E = H_ACT_S + H_ACTIVE - 1;
  localparam int unsigned V_ACT_S = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_E = V_ACT_S + V_ACTIVE - 1;

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_end, v_end;
  logic          h_act, v_act, act;
  logic          hs_nxt, vs_nxt, frame_nxt;
  logic [CW-1:0] col_nxt, row_nxt;

  // Decode the current counter state into next counters and next outputs.
  always_comb begin
    h_end     = (h_cnt == CW'(H_TOTAL - 1));
    v_end     = (v_cnt == CW'(V_TOTAL - 1));
    h_nxt     = h_cnt + CW'(1);
    v_nxt     = v_cnt;
    if (h_end) begin
      h_nxt = '0;
      v_nxt = v_end ? '0 : v_cnt + CW'(1);
    end
    h_act     = (h_cnt >= CW'(H_ACT_S)) && (h_cnt <= CW'(H_ACT_E));
    v_act     = (v_cnt >= CW'(V_ACT_S)) && (v_cnt <= CW'(V_ACT_E));
    act       = h_act && v_act;
    hs_nxt    = (h_cnt < CW'(H_SYNC)) ? HS_POL : ~HS_POL;
    vs_nxt    = (v_cnt < CW'(V_SYNC)) ? VS_POL : ~VS_POL;
    col_nxt   = act ? h_cnt - CW'(H_ACT_S) : '0;
    row_nxt   = act ? v_cnt - CW'(V_ACT_S) : '0;
    frame_nxt = h_end && v_end;
  end

  // Counter and output registers; sync_en low parks everything at reset values.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      HSYNC_Sig       <= ~HS_POL;
      VSYNC_Sig       <= ~VS_POL;
      Ready_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Frame_Sig       <= 1'b0;
    end else if (!sync_en) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      HSYNC_Sig       <= ~HS_POL;
      VSYNC_Sig       <= ~VS_POL;
      Ready_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Frame_Sig       <= 1'b0;
    end else begin
      h_cnt           <= h_nxt;
      v_cnt           <= v_nxt;
      HSYNC_Sig       <= hs_nxt;
      VSYNC_Sig       <= vs_nxt;
      Ready_Sig       <= act;
      Column_Addr_Sig <= col_nxt;
      Row_Addr_Sig    <= row_nxt;
      Frame_Sig       <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: small 8x6 timing plus a partial default-timing run.
module tb_vga_sync_gen;

  logic        vga_clk;
  logic        rst_n, sync_en;
  logic        hs, vs, rdy, frm;
  logic [11:0] col, row;

  logic        rst_n2, sync_en2;
  logic        hs2, vs2, rdy2, frm2;
  logic [11:0] col2, row2;

  int errors = 0;
  int checks = 0;
  int idx;

  vga_sync_gen #(
    .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .sync_en(sync_en),
    .HSYNC_Sig(hs), .VSYNC_Sig(vs), .Ready_Sig(rdy),
    .Column_Addr_Sig(col), .Row_Addr_Sig(row), .Frame_Sig(frm)
  );

  vga_sync_gen dut_def (
    .vga_clk(vga_clk), .rst_n(rst_n2), .sync_en(sync_en2),
    .HSYNC_Sig(hs2), .VSYNC_Sig(vs2), .Ready_Sig(rdy2),
    .Column_Addr_Sig(col2), .Row_Addr_Sig(row2), .Frame_Sig(frm2)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, 32'(hs), 0);
    check({tag, "_vs"}, 32'(vs), 0);
    check({tag, "_rdy"}, 32'(rdy), 0);
    check({tag, "_col"}, 32'(col), 0);
    check({tag, "_row"}, 32'(row), 0);
    check({tag, "_frm"}, 32'(frm), 0);
  endtask

  // One clock; outputs now reflect counter state number idx (8 clocks per line, 6 lines).
  task automatic step();
    int h, v;
    logic er;
    @(negedge vga_clk);
    h  = idx % 8;
    v  = (idx / 8) % 6;
    er = (h >= 3) && (h <= 6) && (v >= 2) && (v <= 4);
    check("hsync", 32'(hs), 32'(h < 2));
    check("vsync", 32'(vs), 32'(v < 1));
    check("ready", 32'(rdy), 32'(er));
    check("col",   32'(col), er ? 32'(h - 3) : 0);
    check("row",   32'(row), er ? 32'(v - 2) : 0);
    check("frame", 32'(frm), 32'((h == 7) && (v == 5)));
    idx++;
  endtask

  initial begin
    int n_hs, n_vs, n_rdy, n_frm, last_frm, col_max, row_max, first_rdy;
    rst_n = 1'b0; sync_en = 1'b0; rst_n2 = 1'b0; sync_en2 = 1'b0;
    repeat (3) @(negedge vga_clk);
    check_idle("reset");

    // Scenarios 1-3: three frames of free-running timing.
    rst_n = 1'b1; sync_en = 1'b1; idx = 0;
    n_hs = 0; n_vs = 0; n_rdy = 0; n_frm = 0; last_frm = -1; col_max = 0; row_max = 0;
    for (int i = 0; i < 144; i++) begin
      step();
      if (i < 48) begin
        n_hs  += int'(hs);
        n_vs  += int'(vs);
        n_rdy += int'(rdy);
      end
      if (int'(col) > col_max) col_max = int'(col);
      if (int'(row) > row_max) row_max = int'(row);
      if (frm) begin
        if (last_frm < 0) check("frm_first", 32'(i), 47);
        else              check("frm_gap", 32'(i - last_frm), 48);
        last_frm = i;
        n_frm++;
      end
    end
    check("hs_cnt", 32'(n_hs), 12);
    check("vs_cnt", 32'(n_vs), 8);
    check("rdy_cnt", 32'(n_rdy), 12);
    check("frm_cnt", 32'(n_frm), 3);
    check("col_max", 32'(col_max), 3);
    check("row_max", 32'(row_max), 2);

    // Scenario 4: drop sync_en while the counter sits at h=5, v=3.
    idx = 0;
    repeat (29) step();
    sync_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge vga_clk);
      check_idle("dis");
    end
    sync_en = 1'b1; idx = 0;
    repeat (48) step();

    // Scenario 5: asynchronous reset in the middle of the active area.
    idx = 0;
    repeat (21) step();
    check("pre_rst_rdy", 32'(rdy), 1);
    #2 rst_n = 1'b0;
    #1 check_idle("arst");
    repeat (2) @(negedge vga_clk);
    check_idle("arst_hold");
    rst_n = 1'b1; idx = 0;
    repeat (48) step();

    // Scenario 6: default 800x600 timing over its first 30 lines.
    rst_n2 = 1'b1; sync_en2 = 1'b1;
    n_hs = 0; n_vs = 0; n_rdy = 0; n_frm = 0; col_max = 0; row_max = 0; first_rdy = -1;
    for (int i = 0; i < 30 * 1056; i++) begin
      @(negedge vga_clk);
      n_hs  += int'(hs2);
      n_vs  += int'(vs2);
      n_rdy += int'(rdy2);
      n_frm += int'(frm2);
      if (int'(col2) > col_max) col_max = int'(col2);
      if (int'(row2) > row_max) row_max = int'(row2);
      if (rdy2 && first_rdy < 0) begin
        first_rdy = i;
        check("def_first_col", 32'(col2), 0);
        check("def_first_row", 32'(row2), 0);
      end
    end
    check("def_first_rdy", 32'(first_rdy), 27 * 1056 + 216);
    check("def_hs_cnt", 32'(n_hs), 30 * 128);
    check("def_vs_cnt", 32'(n_vs), 4 * 1056);
    check("def_rdy_cnt", 32'(n_rdy), 3 * 800);
    check("def_col_max", 32'(col_max), 799);
    check("def_row_max", 32'(row_max), 2);
    check("def_frm_cnt", 32'(n_frm), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
